// File: rtl/maze_game_ctrl_pkg.sv
// Shared encodings for the memory-maze game sequencer: FSM states, one-hot display codes,
// button direction indices and default map geometry.
package maze_game_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_MENU,
        ST_PREVIEW,
        ST_PLAY,
        ST_REQ,
        ST_CHK,
        ST_LOST,
        ST_WON
    } state_e;

    localparam logic [3:0] GS_MENU = 4'b0001;
    localparam logic [3:0] GS_GAME = 4'b0010;
    localparam logic [3:0] GS_LOST = 4'b0100;
    localparam logic [3:0] GS_WON  = 4'b1000;

    localparam logic [2:0] MENU_START = 3'b001;
    localparam logic [2:0] MENU_DIFF  = 3'b010;
    localparam logic [2:0] MENU_INSTR = 3'b100;

    localparam logic [2:0] DIFF_EASY = 3'b001;
    localparam logic [2:0] DIFF_MED  = 3'b010;
    localparam logic [2:0] DIFF_HARD = 3'b100;

    localparam int DIR_UP    = 0;
    localparam int DIR_DOWN  = 1;
    localparam int DIR_LEFT  = 2;
    localparam int DIR_RIGHT = 3;

    localparam int DEF_MAP_WIDTH  = 30;
    localparam int DEF_MAP_HEIGHT = 21;

    // One-hot rotations: toward the low bit wraps 001 -> 100, toward the high bit wraps 100 -> 001.
    function automatic logic [2:0] rot_down(input logic [2:0] v);
        return {v[0], v[2:1]};
    endfunction

    function automatic logic [2:0] rot_up(input logic [2:0] v);
        return {v[1:0], v[2]};
    endfunction

endpackage

// File: rtl/maze_game_ctrl_if.sv
// Map ROM read port: the controller strobes a row address, the ROM returns the wall bits
// for that row one clock later.
interface maze_game_ctrl_if
    import maze_game_ctrl_pkg::*;
#(
    parameter int MAP_WIDTH  = DEF_MAP_WIDTH,
    parameter int MAP_HEIGHT = DEF_MAP_HEIGHT
);
    localparam int AW = $clog2(MAP_HEIGHT);

    logic                 map_rd;
    logic [AW-1:0]        map_addr;
    logic [MAP_WIDTH-1:0] map_row;

    modport master (output map_rd, output map_addr, input map_row);
    modport slave  (input map_rd, input map_addr, output map_row);
endinterface

// File: rtl/maze_game_ctrl_preview_timer.sv
// Loadable down-counter that times the map preview; expired pulses while enabled at count 1.
module preview_timer #(
    parameter int W = 20
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         load_i,
    input  logic [W-1:0] value_i,
    input  logic         en_i,
    output logic         expired_o
);
    logic [W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = value_i;
        end else if (en_i && (cnt_q != '0)) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expired_o = en_i && (cnt_q == W'(1));
endmodule

// File: rtl/maze_game_ctrl.sv
// Game sequencer for the memory-maze: menu, difficulty select, timed map preview and
// move-by-move play with wall lookups through the map ROM port.
module maze_game_ctrl
    import maze_game_ctrl_pkg::*;
#(
    parameter int MAP_WIDTH  = DEF_MAP_WIDTH,
    parameter int MAP_HEIGHT = DEF_MAP_HEIGHT,
    parameter int START_X    = 0,
    parameter int START_Y    = 11,
    parameter int SHOW_EASY  = 1000000,
    parameter int SHOW_MED   = 500000,
    parameter int SHOW_HARD  = 250000
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [3:0]              SCENs,
    input  logic                    sel,
    maze_game_ctrl_if.master        map_if,
    output logic [7:0]              player_x,
    output logic [7:0]              player_y,
    output logic [3:0]              game_state,
    output logic [2:0]              menu_sel,
    output logic [2:0]              difficulty,
    output logic                    show_map,
    output logic                    lost,
    output logic                    won
);
    localparam int AW = $clog2(MAP_HEIGHT);
    localparam int XW = $clog2(MAP_WIDTH);
    localparam int TW = $clog2(SHOW_EASY + 1);

    state_e        state_q;
    logic [3:0]    gs_q;
    logic [2:0]    menu_q, diff_q;
    logic [7:0]    px_q, py_q, tx_q, ty_q;
    logic          show_q, rd_q;
    logic [AW-1:0] addr_q;

    logic          tmr_load, tmr_en, tmr_expired;
    logic [TW-1:0] tmr_value;
    logic          mv_ok;
    logic [7:0]    mtx, mty;

    always_comb begin
        tmr_load  = (state_q == ST_MENU) && sel && (menu_q == MENU_START);
        tmr_en    = (state_q == ST_PREVIEW);
        tmr_value = TW'(SHOW_EASY);
        if (diff_q == DIFF_MED)  tmr_value = TW'(SHOW_MED);
        if (diff_q == DIFF_HARD) tmr_value = TW'(SHOW_HARD);
    end

    preview_timer #(.W(TW)) u_timer (
        .clk       (clk),
        .reset     (reset),
        .load_i    (tmr_load),
        .value_i   (tmr_value),
        .en_i      (tmr_en),
        .expired_o (tmr_expired)
    );

    // The highest-priority pressed direction is the only candidate; if it would leave the
    // map the press is discarded rather than falling through to a lower-priority one.
    always_comb begin
        mv_ok = 1'b0;
        mtx   = px_q;
        mty   = py_q;
        if (SCENs[DIR_UP]) begin
            if (py_q != 8'd0) begin
                mv_ok = 1'b1;
                mty   = py_q - 8'd1;
            end
        end else if (SCENs[DIR_DOWN]) begin
            if (py_q != 8'(MAP_HEIGHT - 1)) begin
                mv_ok = 1'b1;
                mty   = py_q + 8'd1;
            end
        end else if (SCENs[DIR_LEFT]) begin
            if (px_q != 8'd0) begin
                mv_ok = 1'b1;
                mtx   = px_q - 8'd1;
            end
        end else if (SCENs[DIR_RIGHT]) begin
            if (px_q != 8'(MAP_WIDTH - 1)) begin
                mv_ok = 1'b1;
                mtx   = px_q + 8'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_MENU;
            gs_q    <= GS_MENU;
            menu_q  <= MENU_START;
            diff_q  <= DIFF_EASY;
            px_q    <= 8'(START_X);
            py_q    <= 8'(START_Y);
            tx_q    <= 8'd0;
            ty_q    <= 8'd0;
            show_q  <= 1'b0;
            rd_q    <= 1'b0;
            addr_q  <= '0;
        end else begin
            case (state_q)
                ST_MENU: begin
                    if (tmr_load) begin
                        show_q  <= 1'b1;
                        px_q    <= 8'(START_X);
                        py_q    <= 8'(START_Y);
                        gs_q    <= GS_GAME;
                        state_q <= ST_PREVIEW;
                    end else if (SCENs[DIR_UP]) begin
                        menu_q <= rot_down(menu_q);
                    end else if (SCENs[DIR_DOWN]) begin
                        menu_q <= rot_up(menu_q);
                    end else if (menu_q == MENU_DIFF && SCENs[DIR_LEFT]) begin
                        diff_q <= rot_down(diff_q);
                    end else if (menu_q == MENU_DIFF && SCENs[DIR_RIGHT]) begin
                        diff_q <= rot_up(diff_q);
                    end
                end
                ST_PREVIEW: begin
                    if (tmr_expired) begin
                        show_q  <= 1'b0;
                        state_q <= ST_PLAY;
                    end
                end
                ST_PLAY: begin
                    if (mv_ok) begin
                        tx_q    <= mtx;
                        ty_q    <= mty;
                        rd_q    <= 1'b1;
                        addr_q  <= AW'(mty);
                        state_q <= ST_REQ;
                    end
                end
                ST_REQ: begin
                    rd_q    <= 1'b0;
                    state_q <= ST_CHK;
                end
                ST_CHK: begin
                    if (map_if.map_row[tx_q[XW-1:0]]) begin
                        gs_q    <= GS_LOST;
                        state_q <= ST_LOST;
                    end else begin
                        px_q <= tx_q;
                        py_q <= ty_q;
                        if (tx_q == 8'(MAP_WIDTH - 1)) begin
                            gs_q    <= GS_WON;
                            state_q <= ST_WON;
                        end else begin
                            state_q <= ST_PLAY;
                        end
                    end
                end
                ST_LOST, ST_WON: begin
                    if (sel) begin
                        px_q    <= 8'(START_X);
                        py_q    <= 8'(START_Y);
                        gs_q    <= GS_MENU;
                        state_q <= ST_MENU;
                    end
                end
                default: begin
                    gs_q    <= GS_MENU;
                    state_q <= ST_MENU;
                end
            endcase
        end
    end

    assign map_if.map_rd   = rd_q;
    assign map_if.map_addr = addr_q;
    assign player_x        = px_q;
    assign player_y        = py_q;
    assign game_state      = gs_q;
    assign menu_sel        = menu_q;
    assign difficulty      = diff_q;
    assign show_map        = show_q;
    assign lost            = gs_q[2];
    assign won             = gs_q[3];
endmodule

// File: tb/tb_maze_game_ctrl.sv
// Directed bench for maze_game_ctrl with a clocked map ROM model and short preview lengths.
module tb_maze_game_ctrl;
    localparam int MW = 30;
    localparam int MH = 21;
    localparam int SE = 40;
    localparam int SM = 20;
    localparam int SH = 10;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [3:0] SCENs = 4'b0;
    logic       sel = 1'b0;
    logic [7:0] player_x, player_y;
    logic [3:0] game_state;
    logic [2:0] menu_sel, difficulty;
    logic       show_map, lost, won;

    int total = 0;
    int bad = 0;

    logic [MW-1:0] rom [MH];

    maze_game_ctrl_if #(.MAP_WIDTH(MW), .MAP_HEIGHT(MH)) map_if ();

    maze_game_ctrl #(
        .MAP_WIDTH(MW), .MAP_HEIGHT(MH), .START_X(0), .START_Y(11),
        .SHOW_EASY(SE), .SHOW_MED(SM), .SHOW_HARD(SH)
    ) dut (
        .clk(clk), .reset(reset), .SCENs(SCENs), .sel(sel), .map_if(map_if),
        .player_x(player_x), .player_y(player_y), .game_state(game_state),
        .menu_sel(menu_sel), .difficulty(difficulty), .show_map(show_map),
        .lost(lost), .won(won)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (map_if.map_rd) map_if.map_row <= rom[map_if.map_addr];
    end

    task automatic pulse(input logic [3:0] s, input logic b);
        @(negedge clk);
        SCENs = s;
        sel   = b;
        @(negedge clk);
        SCENs = 4'b0;
        sel   = 1'b0;
    endtask

    task automatic move(input logic [3:0] s);
        pulse(s, 1'b0);
        @(negedge clk);
        @(negedge clk);
    endtask

    task automatic wait_preview();
        int n = 0;
        while (show_map && n < 1000) begin
            n++;
            @(negedge clk);
        end
        total++;
        if (n >= 1000) begin bad++; $display("FAIL preview_timeout got=%0d want<1000", n); end
    endtask

    task automatic test_reset();
        #1 reset = 1'b0;
        @(negedge clk);
        @(negedge clk);
        total++; if (game_state !== 4'b0001) begin bad++; $display("FAIL rst_gs got=%b want=0001", game_state); end
        total++; if (menu_sel !== 3'b001) begin bad++; $display("FAIL rst_menu got=%b want=001", menu_sel); end
        total++; if (difficulty !== 3'b001) begin bad++; $display("FAIL rst_diff got=%b want=001", difficulty); end
        total++; if ({player_x, player_y} !== {8'd0, 8'd11}) begin bad++; $display("FAIL rst_pos got=%0d,%0d want=0,11", player_x, player_y); end
        total++; if ({map_if.map_rd, map_if.map_addr, show_map, lost, won} !== 9'b0) begin bad++; $display("FAIL rst_flags got=%b want=0", {map_if.map_rd, map_if.map_addr, show_map, lost, won}); end
        reset = 1'b1;
    endtask

    task automatic test_menu();
        pulse(4'b0010, 1'b0);
        total++; if (menu_sel !== 3'b010) begin bad++; $display("FAIL menu_down1 got=%b want=010", menu_sel); end
        pulse(4'b0010, 1'b0);
        total++; if (menu_sel !== 3'b100) begin bad++; $display("FAIL menu_down2 got=%b want=100", menu_sel); end
        pulse(4'b0001, 1'b0);
        total++; if (menu_sel !== 3'b010) begin bad++; $display("FAIL menu_up got=%b want=010", menu_sel); end
        pulse(4'b1000, 1'b0);
        total++; if (difficulty !== 3'b010) begin bad++; $display("FAIL diff_right got=%b want=010", difficulty); end
        pulse(4'b0000, 1'b1);
        total++; if (game_state !== 4'b0001 || show_map !== 1'b0) begin bad++; $display("FAIL sel_on_diff got=%b want=0001", game_state); end
        pulse(4'b0100, 1'b0);
        pulse(4'b0100, 1'b0);
        total++; if (difficulty !== 3'b100) begin bad++; $display("FAIL diff_left_wrap got=%b want=100", difficulty); end
        pulse(4'b0001, 1'b0);
        pulse(4'b0001, 1'b0);
        total++; if (menu_sel !== 3'b100) begin bad++; $display("FAIL menu_up_wrap got=%b want=100", menu_sel); end
        pulse(4'b1000, 1'b0);
        total++; if (difficulty !== 3'b100) begin bad++; $display("FAIL diff_locked got=%b want=100", difficulty); end
        pulse(4'b0010, 1'b0);
        total++; if (menu_sel !== 3'b001) begin bad++; $display("FAIL menu_down_wrap got=%b want=001", menu_sel); end
    endtask

    task automatic test_preview();
        int n = 0;
        pulse(4'b0000, 1'b1);
        total++; if (game_state !== 4'b0010) begin bad++; $display("FAIL prev_gs got=%b want=0010", game_state); end
        while (show_map && n < 1000) begin
            n++;
            @(negedge clk);
        end
        total++; if (n !== SH) begin bad++; $display("FAIL prev_len got=%0d want=%0d", n, SH); end
        total++; if (game_state !== 4'b0010) begin bad++; $display("FAIL prev_end_gs got=%b want=0010", game_state); end
    endtask

    task automatic test_move_timing();
        pulse(4'b1000, 1'b0);
        total++; if (map_if.map_rd !== 1'b1 || map_if.map_addr !== 5'd11) begin bad++; $display("FAIL mv_strobe got=%b,%0d want=1,11", map_if.map_rd, map_if.map_addr); end
        total++; if (player_x !== 8'd0) begin bad++; $display("FAIL mv_early0 got=%0d want=0", player_x); end
        @(negedge clk);
        total++; if (map_if.map_rd !== 1'b0 || player_x !== 8'd0) begin bad++; $display("FAIL mv_req got=%b,%0d want=0,0", map_if.map_rd, player_x); end
        @(negedge clk);
        total++; if ({player_x, player_y} !== {8'd1, 8'd11}) begin bad++; $display("FAIL mv_done got=%0d,%0d want=1,11", player_x, player_y); end
    endtask

    task automatic test_lost();
        move(4'b0001);
        total++; if (lost !== 1'b1 || won !== 1'b0 || game_state !== 4'b0100) begin bad++; $display("FAIL lost_flag got=%b%b,%b want=10,0100", lost, won, game_state); end
        total++; if ({player_x, player_y} !== {8'd1, 8'd11}) begin bad++; $display("FAIL lost_pos got=%0d,%0d want=1,11", player_x, player_y); end
        pulse(4'b0000, 1'b1);
        total++; if (game_state !== 4'b0001 || lost !== 1'b0) begin bad++; $display("FAIL lost_menu got=%b want=0001", game_state); end
        total++; if ({player_x, player_y} !== {8'd0, 8'd11} || menu_sel !== 3'b001 || difficulty !== 3'b100) begin bad++; $display("FAIL lost_ret got=%0d,%0d,%b,%b want=0,11,001,100", player_x, player_y, menu_sel, difficulty); end
    endtask

    task automatic test_offmap();
        pulse(4'b0000, 1'b1);
        pulse(4'b1000, 1'b0);
        wait_preview();
        total++; if ({player_x, player_y} !== {8'd0, 8'd11}) begin bad++; $display("FAIL prev_ignore got=%0d,%0d want=0,11", player_x, player_y); end
        pulse(4'b0100, 1'b0);
        total++; if (map_if.map_rd !== 1'b0) begin bad++; $display("FAIL left_edge_rd got=%b want=0", map_if.map_rd); end
        @(negedge clk);
        total++; if (player_x !== 8'd0 || game_state !== 4'b0010) begin bad++; $display("FAIL left_edge got=%0d,%b want=0,0010", player_x, game_state); end
        pulse(4'b1001, 1'b0);
        total++; if (map_if.map_rd !== 1'b1 || map_if.map_addr !== 5'd10) begin bad++; $display("FAIL prio_strobe got=%b,%0d want=1,10", map_if.map_rd, map_if.map_addr); end
        @(negedge clk);
        @(negedge clk);
        total++; if ({player_x, player_y} !== {8'd0, 8'd10}) begin bad++; $display("FAIL prio_pos got=%0d,%0d want=0,10", player_x, player_y); end
        for (int i = 0; i < 10; i++) move(4'b0001);
        total++; if ({player_x, player_y} !== {8'd0, 8'd0}) begin bad++; $display("FAIL climb got=%0d,%0d want=0,0", player_x, player_y); end
        pulse(4'b0001, 1'b0);
        total++; if (map_if.map_rd !== 1'b0) begin bad++; $display("FAIL top_edge_rd got=%b want=0", map_if.map_rd); end
        @(negedge clk);
        total++; if (player_y !== 8'd0 || game_state !== 4'b0010) begin bad++; $display("FAIL top_edge got=%0d,%b want=0,0010", player_y, game_state); end
    endtask

    task automatic test_win();
        for (int i = 0; i < 29; i++) begin
            move(4'b1000);
            if (i == 27) begin
                total++; if (won !== 1'b0 || player_x !== 8'd28) begin bad++; $display("FAIL pre_win got=%b,%0d want=0,28", won, player_x); end
            end
        end
        total++; if (won !== 1'b1 || lost !== 1'b0 || game_state !== 4'b1000) begin bad++; $display("FAIL win got=%b%b,%b want=10,1000", won, lost, game_state); end
        total++; if ({player_x, player_y} !== {8'd29, 8'd0}) begin bad++; $display("FAIL win_pos got=%0d,%0d want=29,0", player_x, player_y); end
    endtask

    task automatic test_reset_mid_lookup();
        pulse(4'b0000, 1'b1);
        total++; if (game_state !== 4'b0001 || player_x !== 8'd0) begin bad++; $display("FAIL won_menu got=%b,%0d want=0001,0", game_state, player_x); end
        pulse(4'b0000, 1'b1);
        wait_preview();
        pulse(4'b1000, 1'b0);
        total++; if (map_if.map_rd !== 1'b1) begin bad++; $display("FAIL req_strobe got=%b want=1", map_if.map_rd); end
        #2 reset = 1'b0;
        #1;
        total++; if (map_if.map_rd !== 1'b0 || map_if.map_addr !== 5'd0 || show_map !== 1'b0) begin bad++; $display("FAIL mid_rst_rom got=%b,%0d want=0,0", map_if.map_rd, map_if.map_addr); end
        total++; if (game_state !== 4'b0001 || menu_sel !== 3'b001 || difficulty !== 3'b001) begin bad++; $display("FAIL mid_rst_state got=%b,%b,%b want=0001,001,001", game_state, menu_sel, difficulty); end
        total++; if ({player_x, player_y, lost, won} !== {8'd0, 8'd11, 2'b00}) begin bad++; $display("FAIL mid_rst_pos got=%0d,%0d want=0,11", player_x, player_y); end
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        @(negedge clk);
        total++; if (map_if.map_rd !== 1'b0 || {player_x, player_y} !== {8'd0, 8'd11}) begin bad++; $display("FAIL post_rst got=%b,%0d,%0d want=0,0,11", map_if.map_rd, player_x, player_y); end
    endtask

    initial begin
        for (int r = 0; r < MH; r++) rom[r] = '0;
        rom[10][1] = 1'b1;
        test_reset();
        test_menu();
        test_preview();
        test_move_timing();
        test_lost();
        test_offmap();
        test_win();
        test_reset_mid_lookup();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
